execute_stage_pipelined: RTL and testbench

//  Parametrised execute stage for the pipeline processor: ALU, flag register (CCR),

---
 rtl/execute_stage_pipelined.sv | 205 ++++++++++++++++++++
 tb/tb_execute_stage_pipelined.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_pipelined.sv
// execute_stage_pipelined
//   Execute stage: ALU, condition-code register {C,N,Z}, branch resolution and an
//   iterative shift-add multiplier. Results are held in a registered EX/MEM output
//   with a valid/ready handshake.
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   inValid / inReady             upstream handshake
//   aluOp, func, aluSrc           ALU control; operand B = aluSrc ? imm : readData2
//   branch, brCond                branch control (0 JZ, 1 JN, 2 JC, 3 JMP)
//   readData1, readData2, imm     operands (readData1 doubles as branch target)
//   outValid / outReady           downstream handshake
//   aluResult, branchTaken,
//   branchTarget, flags           registered results; flags = {C,N,Z}
module execute_stage_pipelined #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             aluOp,
  input  logic [3:0]       func,
  input  logic             aluSrc,
  input  logic             branch,
  input  logic [1:0]       brCond,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] imm,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic             branchTaken,
  output logic [WIDTH-1:0] branchTarget,
  output logic [2:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [2:0]       flags_q, flags_d;

  // Multiplier datapath
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_step, mul_final;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               mul_last, commit;

  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, shl_w, shr_w;
  logic             accept, out_free, is_mul;

  // Single-cycle result
  logic [WIDTH-1:0] sc_res, alu_res;
  logic             sc_taken, c_n, zn_upd;
  logic [2:0]       sc_flags, mul_flags;

  assign op_b     = aluSrc ? imm : readData2;
  assign shamt    = op_b[SHW-1:0];
  assign out_free = !out_valid_q || outReady;
  assign inReady  = (state_q == StIdle) && out_free;
  assign accept   = inValid && inReady;
  assign is_mul   = (MUL_EN != 0) && !branch && aluOp && (func == 4'd10);

  // One extra bit on each path carries the carry/borrow/shifted-out bit.
  assign add_w = {1'b0, readData1} + {1'b0, op_b};
  assign sub_w = {1'b0, readData1} - {1'b0, op_b};
  assign inc_w = {1'b0, readData1} + (WIDTH+1)'(1);
  assign dec_w = {1'b0, readData1} - (WIDTH+1)'(1);
  assign shl_w = {1'b0, readData1} << shamt;
  assign shr_w = {readData1, 1'b0} >> shamt;

  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  // cnt_q == WIDTH means all partial products are already summed (stalled completion).
  assign mul_final = (cnt_q == CW'(WIDTH)) ? prod_q : prod_step;
  assign mul_last  = (cnt_q >= CW'(WIDTH - 1));
  assign commit    = (state_q == StBusy) && mul_last && out_free;
  assign mul_flags = {|mul_final[2*WIDTH-1:WIDTH], mul_final[WIDTH-1],
                      (mul_final[WIDTH-1:0] == '0)};

  always_comb begin
    sc_res   = '0;
    sc_taken = 1'b0;
    sc_flags = flags_q;
    alu_res  = readData1;
    c_n      = flags_q[2];
    zn_upd   = 1'b1;
    if (branch) begin
      // A taken conditional branch consumes the flag it tested.
      unique case (brCond)
        2'd0: begin sc_taken = flags_q[0]; if (flags_q[0]) sc_flags[0] = 1'b0; end
        2'd1: begin sc_taken = flags_q[1]; if (flags_q[1]) sc_flags[1] = 1'b0; end
        2'd2: begin sc_taken = flags_q[2]; if (flags_q[2]) sc_flags[2] = 1'b0; end
        2'd3: sc_taken = 1'b1;
      endcase
    end else if (!aluOp) begin
      sc_res = op_b;
    end else begin
      case (func)
        4'd0: alu_res = op_b;
        4'd1: begin alu_res = add_w[WIDTH-1:0]; c_n = add_w[WIDTH]; end
        4'd2: begin alu_res = sub_w[WIDTH-1:0]; c_n = sub_w[WIDTH]; end
        4'd3: alu_res = readData1 & op_b;
        4'd4: alu_res = readData1 | op_b;
        4'd5: alu_res = ~readData1;
        4'd6: begin
          alu_res = shl_w[WIDTH-1:0];
          if (shamt != '0) c_n = shl_w[WIDTH];
        end
        4'd7: begin
          alu_res = shr_w[WIDTH:1];
          if (shamt != '0) c_n = shr_w[0];
        end
        4'd8: begin alu_res = inc_w[WIDTH-1:0]; c_n = inc_w[WIDTH]; end
        4'd9: begin alu_res = dec_w[WIDTH-1:0]; c_n = dec_w[WIDTH]; end
        4'd11: begin c_n = 1'b1; zn_upd = 1'b0; end
        4'd12: begin c_n = 1'b0; zn_upd = 1'b0; end
        default: alu_res = readData1;  // 13-15, and MUL when the multiplier is absent
      endcase
      sc_res   = alu_res;
      sc_flags = {c_n,
                  zn_upd ? alu_res[WIDTH-1] : flags_q[1],
                  zn_upd ? (alu_res == '0) : flags_q[0]};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    taken_d     = taken_q;
    target_d    = target_q;
    flags_d     = flags_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      result_d    = sc_res;
      taken_d     = sc_taken;
      flags_d     = sc_flags;
      if (branch) target_d = readData1;
    end else if (commit) begin
      out_valid_d = 1'b1;
      result_d    = mul_final[WIDTH-1:0];
      taken_d     = 1'b0;
      flags_d     = mul_flags;
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && is_mul) state_d = StBusy;
      StBusy: if (commit) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      flags_q     <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      flags_q     <= flags_d;
      if (accept && is_mul) begin
        prod_q   <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, readData1};
        mplier_q <= op_b;
        cnt_q    <= '0;
      end else if ((state_q == StBusy) && (cnt_q != CW'(WIDTH))) begin
        prod_q   <= prod_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

  assign outValid     = out_valid_q;
  assign aluResult    = result_q;
  assign branchTaken  = taken_q;
  assign branchTarget = target_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_execute_stage_pipelined.sv
module tb_execute_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        aluOp = 1'b0;
  logic [3:0]  func = '0;
  logic        aluSrc = 1'b0;
  logic        branch = 1'b0;
  logic [1:0]  brCond = '0;
  logic [15:0] readData1 = '0;
  logic [15:0] readData2 = '0;
  logic [15:0] imm = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] aluResult;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [2:0]  flags;

  execute_stage_pipelined #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .aluOp(aluOp),
    .func(func), .aluSrc(aluSrc), .branch(branch), .brCond(brCond),
    .readData1(readData1), .readData2(readData2), .imm(imm), .outValid(outValid),
    .outReady(outReady), .aluResult(aluResult), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        tk;
    logic [15:0] tgt;
    logic [2:0]  fl;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          waits = 0;
  logic [2:0]  mflags = '0;
  logic [15:0] mtarget = '0;

  // Reference model: expected outputs, advancing the model CCR and branch target.
  task automatic model(input logic op, input logic [3:0] f, input logic br,
                       input logic [1:0] cond, input logic [15:0] a, input logic [15:0] b,
                       output exp_t e);
    logic c, n, z, tk;
    logic [15:0] r;
    logic [31:0] s;
    int sh;
    c = mflags[2]; n = mflags[1]; z = mflags[0];
    r = '0; tk = 1'b0; s = '0;
    sh = int'(b[3:0]);
    if (br) begin
      case (cond)
        2'd0: begin tk = z; z = 1'b0; end
        2'd1: begin tk = n; n = 1'b0; end
        2'd2: begin tk = c; c = 1'b0; end
        default: tk = 1'b1;
      endcase
      mtarget = a;
    end else if (!op) begin
      r = b;
    end else begin
      case (f)
        4'd0: r = b;
        4'd1: begin s = 32'(a) + 32'(b); r = s[15:0]; c = (s > 32'h0000FFFF); end
        4'd2: begin r = a - b; c = (a < b); end
        4'd3: r = a & b;
        4'd4: r = a | b;
        4'd5: r = ~a;
        4'd6: begin r = a << sh; if (sh != 0) c = a[16 - sh]; end
        4'd7: begin r = a >> sh; if (sh != 0) c = a[sh - 1]; end
        4'd8: begin r = a + 16'd1; c = (a == 16'hFFFF); end
        4'd9: begin r = a - 16'd1; c = (a == 16'h0000); end
        4'd10: begin s = 32'(a) * 32'(b); r = s[15:0]; c = (s[31:16] != 16'h0); end
        4'd11: begin r = a; c = 1'b1; end
        4'd12: begin r = a; c = 1'b0; end
        default: r = a;
      endcase
      if (f != 4'd11 && f != 4'd12) begin z = (r == 16'h0); n = r[15]; end
    end
    mflags = {c, n, z};
    e = {r, tk, mtarget, mflags};
  endtask

  // Scoreboard: each output transfer is popped and compared.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst && outValid && outReady) begin
      got = {aluResult, branchTaken, branchTarget, flags};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output got res=%h tk=%b tgt=%h fl=%b required none",
                 aluResult, branchTaken, branchTarget, flags);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL scoreboard got res=%h tk=%b tgt=%h fl=%b required res=%h tk=%b tgt=%h fl=%b",
                   got.res, got.tk, got.tgt, got.fl, e.res, e.tk, e.tgt, e.fl);
        end
      end
    end
  end

  task automatic issue(input logic op, input logic [3:0] f, input logic src, input logic br,
                       input logic [1:0] cond, input logic [15:0] a, input logic [15:0] r2,
                       input logic [15:0] im);
    exp_t e;
    int t;
    @(negedge clk);
    aluOp = op; func = f; aluSrc = src; branch = br; brCond = cond;
    readData1 = a; readData2 = r2; imm = im; inValid = 1'b1;
    t = 0;
    while (!inReady && t < 100) begin
      waits++;
      @(negedge clk);
      t++;
    end
    if (!inReady) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout inReady=%b required 1", inReady);
      inValid = 1'b0;
    end else begin
      model(op, f, br, cond, a, src ? im : r2, e);
      sb.push_back(e);
      @(posedge clk);
      #1 inValid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_outValid got=%b required 0", outValid); end
    n_cmp++; if (aluResult !== 16'h0) begin n_bad++; $display("FAIL reset_aluResult got=%h required 0000", aluResult); end
    n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b required 000", flags); end
    n_cmp++; if (branchTaken !== 1'b0) begin n_bad++; $display("FAIL reset_branchTaken got=%b required 0", branchTaken); end
    n_cmp++; if (branchTarget !== 16'h0) begin n_bad++; $display("FAIL reset_branchTarget got=%h required 0000", branchTarget); end
    n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_inReady got=%b required 1", inReady); end
    rst = 1'b0;
    mflags = '0;
    mtarget = '0;
  endtask

  task automatic test_alu();
    logic [3:0]  fs [13];
    logic [15:0] as [13];
    logic [15:0] bs [13];
    fs = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13};
    as = '{16'h1234, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h8001, 16'h1234, 16'h0003, 16'h8000,
           16'hFFFF, 16'h0000, 16'h5555, 16'h5555, 16'hA5A5};
    bs = '{16'hABCD, 16'h3C3C, 16'h0F0F, 16'h0000, 16'h0001, 16'h0010, 16'h0001, 16'h000F,
           16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    issue(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 16'h7FFF, 16'h0001, 16'h0);
    n_cmp++;
    if (outValid !== 1'b1 || aluResult !== 16'h8000 || flags !== 3'b010) begin
      n_bad++;
      $display("FAIL add_overflow got v=%b res=%h fl=%b required v=1 res=8000 fl=010",
               outValid, aluResult, flags);
    end
    issue(1'b1, 4'd2, 1'b1, 1'b0, 2'd0, 16'h0005, 16'hEEEE, 16'h0005);
    n_cmp++;
    if (aluResult !== 16'h0000 || flags !== 3'b001) begin
      n_bad++;
      $display("FAIL sub_equal got res=%h fl=%b required res=0000 fl=001", aluResult, flags);
    end
    issue(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0003, 16'h0005, 16'h0);
    n_cmp++;
    if (aluResult !== 16'hFFFE || flags !== 3'b110) begin
      n_bad++;
      $display("FAIL sub_borrow got res=%h fl=%b required res=fffe fl=110", aluResult, flags);
    end
    for (int i = 0; i < 13; i++) issue(1'b1, fs[i], 1'b0, 1'b0, 2'd0, as[i], bs[i], 16'h0);
    issue(1'b0, 4'd1, 1'b1, 1'b0, 2'd0, 16'h1111, 16'h2222, 16'h8765);
    drain();
  endtask

  task automatic test_back_to_back();
    waits = 0;
    issue(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 16'h0100, 16'h0200, 16'h0);
    issue(1'b1, 4'd4, 1'b0, 1'b0, 2'd0, 16'h00F0, 16'h0F00, 16'h0);
    issue(1'b1, 4'd9, 1'b0, 1'b0, 2'd0, 16'h0001, 16'h0000, 16'h0);
    issue(1'b1, 4'd8, 1'b0, 1'b0, 2'd0, 16'h7FFF, 16'h0000, 16'h0);
    n_cmp++;
    if (waits !== 0) begin n_bad++; $display("FAIL back_to_back_stalls got=%0d required 0", waits); end
    drain();
  endtask

  task automatic test_mul();
    int k, busy_bad;
    issue(1'b1, 4'd10, 1'b0, 1'b0, 2'd0, 16'h0100, 16'h0100, 16'h0);
    k = 0; busy_bad = 0;
    while (!outValid && k < 40) begin
      if (inReady !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      k++;
    end
    n_cmp++; if (k != 16) begin n_bad++; $display("FAIL mul_latency got=%0d required 16", k); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL mul_inReady_busy got=%0d required 0", busy_bad); end
    n_cmp++;
    if (aluResult !== 16'h0000 || flags !== 3'b101) begin
      n_bad++;
      $display("FAIL mul_overflow got res=%h fl=%b required res=0000 fl=101", aluResult, flags);
    end
    issue(1'b1, 4'd10, 1'b0, 1'b0, 2'd0, 16'h0003, 16'h0007, 16'h0);
    k = 0;
    while (!outValid && k < 40) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (aluResult !== 16'h0015 || flags !== 3'b000) begin
      n_bad++;
      $display("FAIL mul_small got res=%h fl=%b required res=0015 fl=000", aluResult, flags);
    end
    issue(1'b1, 4'd10, 1'b1, 1'b0, 2'd0, 16'hFFFF, 16'h0000, 16'hFFFF);
    drain();
  endtask

  task automatic test_branch();
    issue(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0005, 16'h0005, 16'h0);
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd0, 16'h0040, 16'h0000, 16'h0);
    n_cmp++;
    if (branchTaken !== 1'b1 || branchTarget !== 16'h0040 || flags !== 3'b000) begin
      n_bad++;
      $display("FAIL jz_taken got tk=%b tgt=%h fl=%b required tk=1 tgt=0040 fl=000",
               branchTaken, branchTarget, flags);
    end
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd0, 16'h0044, 16'h0000, 16'h0);
    n_cmp++;
    if (branchTaken !== 1'b0) begin n_bad++; $display("FAIL jz_repeat got tk=%b required 0", branchTaken); end
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 16'h0123, 16'h0000, 16'h0);
    issue(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0003, 16'h0005, 16'h0);
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd1, 16'h0200, 16'h0000, 16'h0);
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 16'h0300, 16'h0000, 16'h0);
    issue(1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 16'h0400, 16'h0000, 16'h0);
    issue(1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 16'h0F0F, 16'h00FF, 16'h0);
    drain();
  endtask

  task automatic test_stall();
    exp_t e;
    logic [2:0] fl_hold;
    outReady = 1'b0;
    issue(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 16'h0001, 16'h0002, 16'h0);
    fl_hold = mflags;
    aluOp = 1'b1; func = 4'd1; aluSrc = 1'b0; branch = 1'b0;
    readData1 = 16'h0010; readData2 = 16'h0020; imm = 16'h0; inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (outValid !== 1'b1 || aluResult !== 16'h0003 || flags !== fl_hold || inReady !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold got v=%b res=%h fl=%b rdy=%b required v=1 res=0003 fl=%b rdy=0",
                 outValid, aluResult, flags, inReady, fl_hold);
      end
    end
    model(1'b1, 4'd1, 1'b0, 2'd0, 16'h0010, 16'h0020, e);
    sb.push_back(e);
    outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++;
    if (outValid !== 1'b1 || aluResult !== 16'h0030) begin
      n_bad++;
      $display("FAIL stall_release got v=%b res=%h required v=1 res=0030", outValid, aluResult);
    end
    drain();
  endtask

  task automatic test_reset_mul();
    issue(1'b1, 4'd11, 1'b0, 1'b0, 2'd0, 16'h0001, 16'h0000, 16'h0);
    issue(1'b1, 4'd10, 1'b0, 1'b0, 2'd0, 16'h0003, 16'h0005, 16'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outValid !== 1'b0 || flags !== 3'b000 || inReady !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_during_mul got v=%b fl=%b rdy=%b required v=0 fl=000 rdy=1",
               outValid, flags, inReady);
    end
    rst = 1'b0;
    sb.delete();
    mflags = '0;
    mtarget = '0;
    repeat (25) @(posedge clk);
    #1;
    issue(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 16'h0001, 16'h0001, 16'h0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_mul();
    test_branch();
    test_stall();
    test_reset_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
